// File: rtl/trivium_stream_cipher_p.sv
// Trivium keystream engine (W bits/cycle) with INIT warm-up, lifetime limit and coded errors.
// Data latency 1 cycle; a pending output word stalls input (data_ready_o low) until drained.
module trivium_stream_cipher_p #(
  parameter int W           = 8,
  parameter int INIT_ROUNDS = 1152,
  parameter int LIFE_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [79:0]   key_i,
  input  logic [79:0]   iv_i,
  input  logic          load_i,
  input  logic [W-1:0]  data_i,
  input  logic          data_valid_i,
  output logic          data_ready_o,
  output logic [W-1:0]  stream_o,
  output logic          stream_valid_o,
  input  logic          stream_ready_i,
  output logic          busy_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [1:0]    state_o
);

  localparam int INIT_CYC = INIT_ROUNDS / W;
  localparam int CNT_W    = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    READY = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [287:0]      s_q, s_step, s_load;
  logic [W-1:0]      ks;
  logic [CNT_W-1:0]  init_cnt_q;
  logic [LIFE_W-1:0] word_cnt_q;
  logic              rdy, accept, do_load, err_set, expired;
  logic [1:0]        err_code_d;

  // Vector bit k-1 holds Trivium state bit s(k); returns {z, next_state}.
  function automatic logic [288:0] trivium_step(input logic [287:0] s);
    logic t1, t2, t3, z;
    t1 = s[65]  ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90]  & s[91])  ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  assign s_load = {3'b111, 112'b0, iv_i, 13'b0, key_i};

  always_comb begin
    s_step = s_q;
    ks     = '0;
    for (int i = 0; i < W; i++) begin
      {ks[i], s_step} = trivium_step(s_step);
    end
  end

  assign expired      = &word_cnt_q;
  assign accept       = rdy & data_valid_i;
  assign data_ready_o = rdy;
  assign busy_o       = (state_q == INIT);
  assign state_o      = state_q;

  always_comb begin
    state_d    = state_q;
    do_load    = 1'b0;
    rdy        = 1'b0;
    err_set    = 1'b0;
    err_code_d = 2'd0;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          do_load = 1'b1;
          state_d = INIT;
        end
        if (data_valid_i) begin
          err_set    = 1'b1;
          err_code_d = 2'd1;
        end
      end
      INIT: begin
        if (load_i) begin
          do_load = 1'b1;
        end else if (init_cnt_q == CNT_W'(INIT_CYC - 1)) begin
          state_d = READY;
        end
        if (data_valid_i) begin
          err_set    = 1'b1;
          err_code_d = 2'd1;
        end
      end
      READY: begin
        if (expired) begin
          state_d    = ERROR;
          err_set    = 1'b1;
          err_code_d = 2'd2;
        end else begin
          // A load that will be honoured blocks data; an ignored load does not.
          rdy = stream_valid_o ? stream_ready_i : !load_i;
          if (load_i) begin
            if (stream_valid_o) begin
              err_set    = 1'b1;
              err_code_d = 2'd3;
            end else begin
              do_load = 1'b1;
              state_d = INIT;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      s_q            <= '0;
      init_cnt_q     <= '0;
      word_cnt_q     <= '0;
      stream_o       <= '0;
      stream_valid_o <= 1'b0;
      err_o          <= 1'b0;
      err_code_o     <= 2'd0;
    end else begin
      state_q <= state_d;
      err_o   <= err_set;
      if (err_set) err_code_o <= err_code_d;

      if (do_load)                          s_q <= s_load;
      else if (state_q == INIT || accept)   s_q <= s_step;
      else if (state_q == ERROR)            s_q <= '0;

      if (do_load)                init_cnt_q <= '0;
      else if (state_q == INIT)   init_cnt_q <= init_cnt_q + 1'b1;

      if (state_q != READY)       word_cnt_q <= '0;
      else if (accept)            word_cnt_q <= word_cnt_q + 1'b1;

      if (accept) begin
        stream_o       <= data_i ^ ks;
        stream_valid_o <= 1'b1;
      end else if (state_q == ERROR || stream_ready_i) begin
        stream_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/trivium_stream_cipher_p.md
Name: trivium_stream_cipher_p

Overview:
- Parametrised Trivium stream-cipher engine; next generation of the single-byte Trivium controller.
- Loads an 80-bit key and an 80-bit IV in one parallel strobe and runs the 4×288-step warm-up.
- Then XORs W-bit data words with W keystream bits per cycle under a valid/ready handshake.
- Adds rekey-on-demand, a key-lifetime limit, output backpressure and coded error reporting.
- Sits between the host data interface and the link framer.

Parameters:
- W, 8: keystream/data bits per cycle. Legal values: 1..64, and W must divide INIT_ROUNDS.
- INIT_ROUNDS, 1152: warm-up steps with keystream discarded.
- LIFE_W, 32: width of the word counter; key expires after 2^LIFE_W−1 words.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- key_i  in  80  key; key_i[k-1] loads state bit s(k)
- iv_i  in  80  IV; iv_i[k-1] loads state bit s(93+k)
- load_i  in  1  single-cycle strobe: capture key_i/iv_i and start INIT
- data_i  in  W  plaintext/ciphertext word
- data_valid_i  in  1  data_i valid
- data_ready_o  out  1  block accepts data this cycle
- stream_o  out  W  data_i XOR keystream
- stream_valid_o  out  1  stream_o valid
- stream_ready_i  in  1  downstream accepts stream_o
- busy_o  out  1  high in INIT
- err_o  out  1  one-cycle error pulse
- err_code_o  out  2  1 = data without key; 2 = key lifetime expired; 3 = load while output pending; held until next error or reset
- state_o  out  2  0 = IDLE, 1 = INIT, 2 = READY, 3 = ERROR

Behaviour:
- Reset values: all outputs 0, state IDLE, 288-bit state 0, counters 0.
- Trivium step:
  - t1 = s66^s93; t2 = s162^s177; t3 = s243^s288; z = t1^t2^t3.
  - t1 ^= s91&s92 ^ s171; t2 ^= s175&s176 ^ s264; t3 ^= s286&s287 ^ s69.
  - Shift: s1 ← t3, s94 ← t1, s178 ← t2; all other bits shift up by one.
  - W steps are unrolled per cycle. Word bit i carries the i-th generated bit (bit 0 first).
- Load: s1..80 = key, s81..93 = 0; s94..173 = iv, s174..177 = 0; s178..285 = 0; s286..288 = 1.
- IDLE:
  - load_i → INIT.
  - data_valid_i → err_o pulse, code 1, data dropped.
  - data_ready_o = 0.
- INIT:
  - Runs W steps/cycle for INIT_ROUNDS/W cycles; busy_o = 1; data_ready_o = 0.
  - Then → READY with word counter cleared.
  - data_valid_i during INIT → code 1 pulse.
  - load_i during INIT → state reloaded, cycle count restarts.
- READY:
  - data_ready_o = !stream_valid_o || stream_ready_i.
  - On accept: stream_o <= data_i ^ z[W-1:0] on the next edge (latency 1), stream_valid_o <= 1, state advances W steps, word counter +1.
  - The keystream never advances without an accept.
  - stream_valid_o drops when stream_ready_i is high and no new accept occurs in the same cycle.
  - Accept and drain in the same cycle are allowed (full throughput, 1 word/cycle).
- Lifetime: the accept that makes the counter all-ones completes normally. Next cycle: err code 2 → ERROR.
- load_i in READY:
  - stream_valid_o = 0 → restart INIT.
  - stream_valid_o = 1 → err code 3, load ignored, pending word kept.
- ERROR: one cycle; clears stream_valid_o and the 288-bit state → IDLE. A load_i arriving while in ERROR is ignored.
- Simultaneous load_i and data_valid_i in READY:
  - load takes priority; data_ready_o is forced to 0 that cycle.
  - With stream_valid_o = 1 the load is ignored (code 3, as above) and data is accepted normally.
- Async rst mid-operation: immediate return to reset values; any pending word is lost.

Test Plan:
- Reset, then idle 10 cycles → state_o = 0, all outputs 0, data_ready_o = 0.
- W=8, load key=0, iv=0 → busy_o high exactly 144 cycles, then state_o = 2. Feed 16 bytes 0x00 → stream_o equals a C model of the step above bit-exact. Re-encrypt the output after reload → original plaintext returned.
- data_valid_i = 1, data_i = 0xA5 in IDLE and again at INIT cycle 50 → two err_o pulses with code 1, no stream_valid_o, INIT count unaffected.
- READY, stream_ready_i low 3 cycles after one accept → stream_o held, data_ready_o = 0, keystream not advanced. Release → next word matches the model's word 2. Back-to-back words give 1 word/cycle.
- LIFE_W=4 → 15 words accepted, then err code 2, state ERROR for 1 cycle, then IDLE. 16th valid word → code 1.
- load_i at INIT cycle 70 → INIT restarts (144 further cycles). load_i with a pending output → code 3. rst pulse mid-READY → all outputs 0 immediately.
